// File: rtl/sat_accumulator.sv
// sat_accumulator
// Accumulation stage that sits directly after the signed adder. Each accepted
// sample registers the adder's wrapped sum, clamped to the signed range when
// the adder flags overflow. The running total is fed back to the adder through
// o_acc. After a programmed number of samples, the final total is offered on a
// valid/ready handshake.
//
// Ports:
//   i_clk      clock, all state changes on the rising edge
//   i_rst_n    synchronous active-low reset
//   i_start    begin a batch (honoured only in IDLE)
//   i_len      samples per batch, latched at start
//   i_valid    adder output holds a valid sample
//   o_in_ready high in ACCUM; a sample is taken on i_valid & o_in_ready
//   i_sum      adder sum (sample + o_acc, wrapped)
//   i_carry    adder signed-overflow flag
//   o_acc      running accumulator, drives the adder's i_b input
//   o_result   final batch result, valid while o_valid
//   o_valid    result available (DONE)
//   i_ready    downstream takes the result on o_valid & i_ready
//   o_sat      sticky flag: a saturation occurred in the current/last batch
//   o_busy     high in ACCUM or DONE
module sat_accumulator #(
  parameter int BITS  = 4,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_valid,
  output logic             o_in_ready,
  input  logic [BITS-1:0]  i_sum,
  input  logic             i_carry,
  output logic [BITS-1:0]  o_acc,
  output logic [BITS-1:0]  o_result,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_sat,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The adder's MSB after a signed overflow has the opposite sign of the true
  // result. A set MSB therefore means the true sum overflowed upward, and a
  // clear MSB means it overflowed downward.
  function automatic logic [BITS-1:0] saturate(input logic [BITS-1:0] sum,
                                               input logic            carry);
    logic [BITS-1:0] max_v;
    logic [BITS-1:0] min_v;
    max_v = {1'b0, {(BITS-1){1'b1}}};
    min_v = {1'b1, {(BITS-1){1'b0}}};
    if (!carry) begin
      saturate = sum;
    end else if (sum[BITS-1]) begin
      saturate = max_v;
    end else begin
      saturate = min_v;
    end
  endfunction

  state_t           state_r, state_s;
  logic [BITS-1:0]  acc_r, acc_s;
  logic [BITS-1:0]  result_r, result_s;
  logic             sat_r, sat_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] len_r, len_s;

  // Next-state and next-datapath logic for the batch sequencer.
  always_comb begin
    state_s  = state_r;
    acc_s    = acc_r;
    result_s = result_r;
    sat_s    = sat_r;
    cnt_s    = cnt_r;
    len_s    = len_r;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          len_s = i_len;
          acc_s = {BITS{1'b0}};
          cnt_s = {CNT_W{1'b0}};
          sat_s = 1'b0;
          if (i_len == {CNT_W{1'b0}}) begin
            // An empty batch goes straight to DONE with a zero result.
            result_s = {BITS{1'b0}};
            state_s  = DONE;
          end else begin
            state_s = ACCUM;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCUM: begin
        if (i_valid) begin
          acc_s = saturate(i_sum, i_carry);
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (i_carry) begin
            sat_s = 1'b1;
          end else begin
            sat_s = sat_r;
          end
          if (cnt_s == len_r) begin
            // Load the result on the same edge as the final sample so that
            // o_result equals o_acc for the whole time DONE lasts.
            result_s = acc_s;
            state_s  = DONE;
          end else begin
            state_s = ACCUM;
          end
        end else begin
          state_s = ACCUM;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r  <= IDLE;
      acc_r    <= {BITS{1'b0}};
      result_r <= {BITS{1'b0}};
      sat_r    <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      len_r    <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_s;
      acc_r    <= acc_s;
      result_r <= result_s;
      sat_r    <= sat_s;
      cnt_r    <= cnt_s;
      len_r    <= len_s;
    end
  end

  // All outputs come from registers or are decoded from the registered state.
  assign o_acc      = acc_r;
  assign o_result   = result_r;
  assign o_sat      = sat_r;
  assign o_valid    = (state_r == DONE);
  assign o_in_ready = (state_r == ACCUM);
  assign o_busy     = (state_r != IDLE);

endmodule

// File: tb/tb_sat_accumulator.sv
// Scoreboard bench for sat_accumulator. The bench models the upstream adder
// from its own integer accumulator model. An expected result is queued when a
// batch's final sample (or an empty batch) is driven. It is popped and
// compared when the DUT raises o_valid.
module tb_sat_accumulator;
  localparam int BITS  = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             i_rst_n;
  logic             i_start;
  logic [CNT_W-1:0] i_len;
  logic             i_valid;
  logic             o_in_ready;
  logic [BITS-1:0]  i_sum;
  logic             i_carry;
  logic [BITS-1:0]  o_acc;
  logic [BITS-1:0]  o_result;
  logic             o_valid;
  logic             i_ready;
  logic             o_sat;
  logic             o_busy;

  always #5 clk = ~clk;

  sat_accumulator #(.BITS(BITS), .CNT_W(CNT_W)) dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_len      (i_len),
    .i_valid    (i_valid),
    .o_in_ready (o_in_ready),
    .i_sum      (i_sum),
    .i_carry    (i_carry),
    .o_acc      (o_acc),
    .o_result   (o_result),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_sat      (o_sat),
    .o_busy     (o_busy)
  );

  typedef struct {
    int res;
    int sat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_acc;
  int   m_sat;
  int   m_len;
  int   m_cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int acc_s32();
    return int'($signed(o_acc));
  endfunction

  function automatic int res_s32();
    return int'($signed(o_result));
  endfunction

  task automatic do_reset;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    tick();
    chk("rst_acc", acc_s32(), 0);
    chk("rst_result", res_s32(), 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_in_ready", o_in_ready, 0);
    chk("rst_sat", o_sat, 0);
    chk("rst_busy", o_busy, 0);
    i_rst_n = 1'b1;
    m_acc = 0;
    m_sat = 0;
    sb_q.delete();
  endtask

  task automatic start_batch(input int len);
    exp_t e;
    i_start = 1'b1;
    i_len   = len[CNT_W-1:0];
    tick();
    i_start = 1'b0;
    m_acc = 0;
    m_sat = 0;
    m_len = len;
    m_cnt = 0;
    chk("start_busy", o_busy, 1);
    chk("start_acc", acc_s32(), 0);
    chk("start_sat", o_sat, 0);
    if (len == 0) begin
      e.res = 0;
      e.sat = 0;
      sb_q.push_back(e);
      chk("len0_in_ready", o_in_ready, 0);
    end else begin
      chk("start_in_ready", o_in_ready, 1);
    end
  endtask

  // Drive one sample, optionally preceded by idle cycles that must hold state.
  task automatic send(input int val, input int gap);
    int   s;
    exp_t e;
    for (int g = 0; g < gap; g++) begin
      i_valid = 1'b0;
      i_sum   = 4'($urandom_range(0, 15));
      i_carry = 1'b1;
      tick();
      chk("gap_hold_acc", acc_s32(), m_acc);
      chk("gap_in_ready", o_in_ready, 1);
    end
    s       = m_acc + val;
    i_sum   = s[BITS-1:0];
    i_carry = (s > 7 || s < -8);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    if (s > 7) begin
      m_acc = 7;
      m_sat = 1;
    end else if (s < -8) begin
      m_acc = -8;
      m_sat = 1;
    end else begin
      m_acc = s;
    end
    m_cnt++;
    chk("acc", acc_s32(), m_acc);
    chk("sat_flag", o_sat, m_sat);
    if (m_cnt == m_len) begin
      e.res = m_acc;
      e.sat = m_sat;
      sb_q.push_back(e);
    end else begin
      chk("mid_in_ready", o_in_ready, 1);
    end
  endtask

  // Wait for the result, stall for 'hold' cycles with i_start pulsed (it must
  // be ignored), then complete the handshake and confirm a clean return to IDLE.
  task automatic collect(input int hold);
    exp_t e;
    int   waited;
    e.res  = 0;
    e.sat  = 0;
    waited = 0;
    while (!o_valid && waited < 20) begin
      tick();
      waited++;
    end
    chk("valid_latency", waited, 0);
    if (sb_q.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = sb_q.pop_front();
    end
    chk("result", res_s32(), e.res);
    chk("result_eq_acc", acc_s32(), e.res);
    chk("done_sat", o_sat, e.sat);
    chk("done_in_ready", o_in_ready, 0);
    chk("done_busy", o_busy, 1);
    for (int h = 0; h < hold; h++) begin
      i_ready = 1'b0;
      i_start = 1'b1;
      i_len   = 4'd3;
      tick();
      chk("hold_valid", o_valid, 1);
      chk("hold_result", res_s32(), e.res);
      chk("hold_acc", acc_s32(), e.res);
    end
    i_start = 1'b1;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    i_start = 1'b0;
    chk("post_valid", o_valid, 0);
    chk("post_busy", o_busy, 0);
    chk("post_in_ready", o_in_ready, 0);
    chk("idle_result", res_s32(), e.res);
    chk("idle_sat", o_sat, e.sat);
  endtask

  initial begin
    int len;
    i_rst_n = 1'b1;
    i_start = 1'b0;
    i_len   = 4'd0;
    i_valid = 1'b0;
    i_sum   = 4'd0;
    i_carry = 1'b0;
    i_ready = 1'b0;
    tick();
    do_reset();

    // Samples offered while IDLE have no effect.
    i_valid = 1'b1;
    i_sum   = 4'd5;
    i_carry = 1'b0;
    tick();
    tick();
    i_valid = 1'b0;
    chk("idle_valid_acc", acc_s32(), 0);
    chk("idle_valid_busy", o_busy, 0);

    // Plain accumulation: 3 + 4 = 7.
    start_batch(2);
    send(3, 0);
    send(4, 0);
    collect(0);

    // Positive saturation mid-batch: 5, 5 -> 7, then -2 -> 5.
    start_batch(3);
    send(5, 0);
    send(5, 1);
    send(-2, 0);
    collect(0);

    // Negative saturation, and a stalled result with start ignored in DONE.
    start_batch(2);
    send(-8, 0);
    send(-1, 0);
    collect(3);

    // Empty batch.
    start_batch(0);
    collect(1);

    // Reset during a batch discards it.
    start_batch(3);
    send(2, 0);
    do_reset();
    start_batch(1);
    send(2, 0);
    collect(0);

    // Reset while a result is pending.
    start_batch(1);
    send(-3, 0);
    do_reset();

    // Random batches, including the maximum length.
    for (int b = 0; b < 5; b++) begin
      len = (b == 0) ? 15 : $urandom_range(1, 15);
      start_batch(len);
      for (int k = 0; k < len; k++) begin
        send($urandom_range(0, 15) - 8, $urandom_range(0, 1));
      end
      collect($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sat_accumulator.md
Name: sat_accumulator

Overview:
Sequential accumulation stage directly downstream of the signed adder (fulladder). It registers the adder's sum/overflow each accepted sample, saturates on signed overflow, and feeds the running total back to the adder's i_b input via o_acc. After a programmed number of samples it presents the final result on a valid/ready output handshake.

Parameters:
BITS, 4, data width in two's complement; must match the adder's BITS.
CNT_W, 4, width of the sample-count register and i_len.

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst_n  input  1  synchronous active-low reset
i_start  input  1  begin a batch; accepted only in IDLE
i_len  input  CNT_W  samples per batch, latched when i_start accepted
i_valid  input  1  adder output (i_sum/i_carry) holds a valid sample this cycle
o_in_ready  output  1  high only in ACCUM; sample accepted when i_valid & o_in_ready
i_sum  input  BITS  adder o_sum (sample + o_acc, wrapped)
i_carry  input  1  adder o_carry (signed overflow flag)
o_acc  output  BITS  running accumulator; drives adder i_b
o_result  output  BITS  final batch result; equals o_acc while o_valid
o_valid  output  1  result available (DONE state)
i_ready  input  1  downstream accepts result when o_valid & i_ready
o_sat  output  1  sticky: at least one saturation in current/last batch
o_busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (i_rst_n low at a rising edge): state IDLE; o_acc=0, o_result=0, o_valid=0, o_in_ready=0, o_sat=0, o_busy=0, count=0, latched length=0. Reset overrides all other inputs, including mid-batch and during DONE; a partially accumulated batch is discarded and no result is produced.
- FSM states IDLE, ACCUM, DONE.
- IDLE: i_valid ignored. On i_start: latch i_len, clear o_acc, count, o_sat. If i_len==0 go to DONE (o_result=0, o_valid=1 next cycle), else go to ACCUM.
- ACCUM: o_in_ready=1. Per accepted sample, o_acc <= saturate(i_sum, i_carry), count <= count+1. If count+1 == latched length, go to DONE in the same edge. Cycles with i_valid=0 hold all state. i_start ignored.
- Saturation rule: i_carry=0 -> i_sum unchanged. i_carry=1 and i_sum[BITS-1]=1 (positive overflow) -> 2^(BITS-1)-1. i_carry=1 and i_sum[BITS-1]=0 (negative overflow) -> -2^(BITS-1). Any saturation sets o_sat; it stays set until the next accepted i_start or reset.
- DONE: o_valid=1, o_result=o_acc, o_acc held stable. On i_ready go to IDLE; o_valid drops the next cycle. o_acc, o_result, and o_sat keep their values in IDLE until the next start. i_start in DONE is ignored, including in the handshake cycle; the earliest new start is the first IDLE cycle.
- Latency: the result is valid the cycle after the last sample is accepted; one sample per cycle maximum throughput. o_result, o_valid, o_in_ready, and o_busy are registered or decoded from registered state only; there is no combinational path from i_* inputs to outputs.
- Count arithmetic is unsigned CNT_W; the maximum batch is 2^CNT_W-1 samples.

Test Plan:
- BITS=4, len=2, samples 3,4 (i_sum=3 then 7, i_carry=0) -> o_result=7, o_sat=0, o_valid one cycle after second sample.
- len=3, samples 5,5,-2 (sums 5, 1010b with carry=1, 5) -> second step saturates to 7, o_result=5, o_sat=1.
- len=2, samples -8,-1 (sums -8, 0111b with carry=1) -> saturates to -8 (1000b), o_result=-8, o_sat=1.
- len=2, i_ready held low 3 cycles after DONE -> o_valid and o_result stable for those 3 cycles; IDLE the cycle after i_ready=1; i_start during DONE ignored.
- i_len=0 -> o_valid the cycle after start, o_result=0, no samples accepted (o_in_ready never high); i_valid pulses in IDLE have no effect.
- Reset asserted after 1 of 3 samples -> all outputs 0 the next cycle, state IDLE; a new len=1 batch with sample 2 -> o_result=2, o_sat=0.
